mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 121 ++++++++++++
 tb/tb_mem_stage.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage -- memory stage of a 64-bit five-stage pipeline.
//
// Purpose:
//   Resolves branches combinationally (PCSrc / Flush / Branch_Target) and
//   performs aligned doubleword loads and stores against a small local data
//   memory. Its results are registered into the MEM/WB pipeline fields. It
//   also flags misaligned accesses and counts taken branches, saturating
//   at 0xFFFF.
//
// Ports:
//   clk, reset          rising-edge clock, async active-high reset
//   EX_MEM_*            EX/MEM pipeline fields (Rd, ALU, store data, branch
//                       target, flags, control bits)
//   PCSrc, Flush        branch taken (combinational, Flush == PCSrc)
//   Branch_Target       branch target (combinational copy of EX_MEM_Adder)
//   MEM_WB_*            registered MEM/WB pipeline fields
//   Misaligned          registered, high for one cycle after a misaligned access
//   Taken_Count         registered saturating count of taken branches
// ---------------------------------------------------------------------------
module mem_stage #(
  parameter int MEM_BYTES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  EX_MEM_Rd,
  input  logic [63:0] EX_MEM_ALU,
  input  logic [63:0] EX_MEM_MUX_FB,
  input  logic [63:0] EX_MEM_Adder,
  input  logic        EX_MEM_zero,
  input  logic        EX_MEM_Great,
  input  logic        EX_MEM_BranchEq,
  input  logic        EX_MEM_BranchGt,
  input  logic        EX_MEM_MemRead,
  input  logic        EX_MEM_MemWrite,
  input  logic        EX_MEM_RegWrite,
  input  logic        EX_MEM_MemtoReg,
  output logic        PCSrc,
  output logic [63:0] Branch_Target,
  output logic        Flush,
  output logic [4:0]  MEM_WB_Rd,
  output logic [63:0] MEM_WB_ReadData,
  output logic [63:0] MEM_WB_ALU,
  output logic        MEM_WB_RegWrite,
  output logic        MEM_WB_MemtoReg,
  output logic        Misaligned,
  output logic [15:0] Taken_Count
);

  localparam int AW    = $clog2(MEM_BYTES);
  localparam int WORDS = MEM_BYTES / 8;
  localparam int WW    = AW - 3;

  // Memory is held as doublewords: only aligned 8-byte accesses ever touch
  // it, and bits [7:0] of a word are the byte at the lowest address, which
  // gives the little-endian byte layout directly.
  logic [63:0] mem [WORDS];

  logic [AW-1:0] effAddr;
  logic [WW-1:0] wordIdx;
  logic          accessMisaligned;
  logic          doStore;
  logic          doLoad;
  logic [63:0]   readData;
  logic          unusedAddrBits;

  // Branch resolution stays purely combinational, including during reset.
  assign PCSrc         = (EX_MEM_BranchEq & EX_MEM_zero) | (EX_MEM_BranchGt & EX_MEM_Great);
  assign Flush         = PCSrc;
  assign Branch_Target = EX_MEM_Adder;

  // Address wraps modulo MEM_BYTES; the upper ALU bits are deliberately dropped.
  assign effAddr        = EX_MEM_ALU[AW-1:0];
  assign wordIdx        = effAddr[AW-1:3];
  assign unusedAddrBits = ^EX_MEM_ALU[63:AW];

  assign accessMisaligned = (EX_MEM_MemRead | EX_MEM_MemWrite) & (|effAddr[2:0]);

  // A simultaneous read+write is a store only; it returns no read data.
  assign doStore = EX_MEM_MemWrite & ~accessMisaligned;
  assign doLoad  = EX_MEM_MemRead & ~EX_MEM_MemWrite & ~accessMisaligned;

  assign readData = doLoad ? mem[wordIdx] : 64'd0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < WORDS; i++) begin
        mem[i] <= 64'd0;
      end
    end else if (doStore) begin
      mem[wordIdx] <= EX_MEM_MUX_FB;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      MEM_WB_Rd       <= 5'd0;
      MEM_WB_ReadData <= 64'd0;
      MEM_WB_ALU      <= 64'd0;
      MEM_WB_RegWrite <= 1'b0;
      MEM_WB_MemtoReg <= 1'b0;
      Misaligned      <= 1'b0;
    end else begin
      MEM_WB_Rd       <= EX_MEM_Rd;
      MEM_WB_ReadData <= readData;
      MEM_WB_ALU      <= EX_MEM_ALU;
      MEM_WB_RegWrite <= EX_MEM_RegWrite;
      MEM_WB_MemtoReg <= EX_MEM_MemtoReg;
      Misaligned      <= accessMisaligned;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Taken_Count <= 16'd0;
    end else if (PCSrc && (Taken_Count != 16'hFFFF)) begin
      Taken_Count <= Taken_Count + 16'd1;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_stage -- directed self-checking bench for mem_stage (MEM_BYTES=64).
// Expected MEM/WB fields are pushed to exp_q when a step is driven and
// popped after the following rising edge.
// ---------------------------------------------------------------------------
module tb_mem_stage;

  logic        clk;
  logic        reset;
  logic [4:0]  EX_MEM_Rd;
  logic [63:0] EX_MEM_ALU;
  logic [63:0] EX_MEM_MUX_FB;
  logic [63:0] EX_MEM_Adder;
  logic        EX_MEM_zero;
  logic        EX_MEM_Great;
  logic        EX_MEM_BranchEq;
  logic        EX_MEM_BranchGt;
  logic        EX_MEM_MemRead;
  logic        EX_MEM_MemWrite;
  logic        EX_MEM_RegWrite;
  logic        EX_MEM_MemtoReg;
  logic        PCSrc;
  logic [63:0] Branch_Target;
  logic        Flush;
  logic [4:0]  MEM_WB_Rd;
  logic [63:0] MEM_WB_ReadData;
  logic [63:0] MEM_WB_ALU;
  logic        MEM_WB_RegWrite;
  logic        MEM_WB_MemtoReg;
  logic        Misaligned;
  logic [15:0] Taken_Count;

  int checks = 0;
  int errors = 0;
  logic [15:0]  exp_cnt;
  logic [135:0] exp_q[$];

  mem_stage #(.MEM_BYTES(64)) dut (
    .clk(clk), .reset(reset),
    .EX_MEM_Rd(EX_MEM_Rd), .EX_MEM_ALU(EX_MEM_ALU),
    .EX_MEM_MUX_FB(EX_MEM_MUX_FB), .EX_MEM_Adder(EX_MEM_Adder),
    .EX_MEM_zero(EX_MEM_zero), .EX_MEM_Great(EX_MEM_Great),
    .EX_MEM_BranchEq(EX_MEM_BranchEq), .EX_MEM_BranchGt(EX_MEM_BranchGt),
    .EX_MEM_MemRead(EX_MEM_MemRead), .EX_MEM_MemWrite(EX_MEM_MemWrite),
    .EX_MEM_RegWrite(EX_MEM_RegWrite), .EX_MEM_MemtoReg(EX_MEM_MemtoReg),
    .PCSrc(PCSrc), .Branch_Target(Branch_Target), .Flush(Flush),
    .MEM_WB_Rd(MEM_WB_Rd), .MEM_WB_ReadData(MEM_WB_ReadData),
    .MEM_WB_ALU(MEM_WB_ALU), .MEM_WB_RegWrite(MEM_WB_RegWrite),
    .MEM_WB_MemtoReg(MEM_WB_MemtoReg), .Misaligned(Misaligned),
    .Taken_Count(Taken_Count)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [135:0] obs_fields();
    return {MEM_WB_Rd, MEM_WB_ReadData, MEM_WB_ALU, MEM_WB_RegWrite, MEM_WB_MemtoReg, Misaligned};
  endfunction

  task automatic check(input string tag, input logic [135:0] obs, input logic [135:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_idle();
    EX_MEM_Rd = 5'd0; EX_MEM_ALU = 64'd0; EX_MEM_MUX_FB = 64'd0; EX_MEM_Adder = 64'd0;
    EX_MEM_zero = 1'b0; EX_MEM_Great = 1'b0; EX_MEM_BranchEq = 1'b0; EX_MEM_BranchGt = 1'b0;
    EX_MEM_MemRead = 1'b0; EX_MEM_MemWrite = 1'b0; EX_MEM_RegWrite = 1'b0; EX_MEM_MemtoReg = 1'b0;
  endtask

  // Driver: one instruction through the stage. br = {beq, bgt, zero, great}.
  task automatic step(input string tag, input logic [4:0] rd, input logic [63:0] alu,
                      input logic [63:0] data, input logic mr, input logic mw,
                      input logic rw, input logic m2r, input logic [3:0] br,
                      input logic [63:0] adder, input logic exp_taken,
                      input logic [63:0] exp_rdata, input logic exp_mis);
    logic [135:0] e;
    @(negedge clk);
    EX_MEM_Rd = rd; EX_MEM_ALU = alu; EX_MEM_MUX_FB = data; EX_MEM_Adder = adder;
    EX_MEM_MemRead = mr; EX_MEM_MemWrite = mw; EX_MEM_RegWrite = rw; EX_MEM_MemtoReg = m2r;
    {EX_MEM_BranchEq, EX_MEM_BranchGt, EX_MEM_zero, EX_MEM_Great} = br;
    exp_q.push_back({rd, exp_rdata, alu, rw, m2r, exp_mis});
    #1;
    check({tag, ".pcsrc"}, {135'd0, PCSrc}, {135'd0, exp_taken});
    check({tag, ".flush"}, {135'd0, Flush}, {135'd0, exp_taken});
    check({tag, ".target"}, {72'd0, Branch_Target}, {72'd0, adder});
    if (exp_taken && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check({tag, ".memwb"}, obs_fields(), e);
    check({tag, ".count"}, {120'd0, Taken_Count}, {120'd0, exp_cnt});
  endtask

  initial begin
    set_idle();
    exp_cnt = 16'd0;
    reset = 1'b1;
    #2;
    check("reset_async.memwb", obs_fields(), 136'd0);
    check("reset_async.count", {120'd0, Taken_Count}, 136'd0);
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    //     tag          rd     alu              data                    mr mw rw m2r br      adder     tk  rdata                  mis
    step("store8",     5'd3,  64'd8,  64'h1122334455667788, 0, 1, 0, 0, 4'b0000, 64'd0,   0, 64'd0,                 0);
    step("load8",      5'd5,  64'd8,  64'd0,                1, 0, 1, 1, 4'b0000, 64'd0,   0, 64'h1122334455667788,  0);
    step("store_wrap", 5'd6,  64'd72, 64'hA5A50000DEADBEEF, 0, 1, 0, 0, 4'b0000, 64'd0,   0, 64'd0,                 0);
    step("load_wrap",  5'd7,  64'd8,  64'd0,                1, 0, 1, 1, 4'b0000, 64'd0,   0, 64'hA5A50000DEADBEEF,  0);
    step("mis_store",  5'd8,  64'd13, 64'hFFFFFFFFFFFFFFFF, 0, 1, 0, 0, 4'b0000, 64'd0,   0, 64'd0,                 1);
    step("mis_load",   5'd9,  64'd13, 64'd0,                1, 0, 1, 1, 4'b0000, 64'd0,   0, 64'd0,                 1);
    step("after_mis",  5'd10, 64'd8,  64'd0,                1, 0, 1, 1, 4'b0000, 64'd0,   0, 64'hA5A50000DEADBEEF,  0);
    step("rdwr_both",  5'd11, 64'd24, 64'h0123456789ABCDEF, 1, 1, 0, 0, 4'b0000, 64'd0,   0, 64'd0,                 0);
    step("load24",     5'd12, 64'd24, 64'd0,                1, 0, 1, 1, 4'b0000, 64'd0,   0, 64'h0123456789ABCDEF,  0);
    step("alu_pass",   5'd31, 64'hFFFFFFFFFFFFFFFF, 64'd0,  0, 0, 1, 0, 4'b0000, 64'd0,   0, 64'd0,                 0);
    step("beq_taken",  5'd13, 64'd32, 64'h77,               0, 1, 1, 0, 4'b1010, 64'h40,  1, 64'd0,                 0);
    step("load32",     5'd14, 64'd32, 64'd0,                1, 0, 1, 1, 4'b0000, 64'd0,   0, 64'h77,                0);
    step("bgt_not",    5'd15, 64'd0,  64'd0,                0, 0, 0, 0, 4'b0110, 64'h80,  0, 64'd0,                 0);
    step("bgt_taken",  5'd16, 64'd0,  64'd0,                0, 0, 0, 0, 4'b0101, 64'h88,  1, 64'd0,                 0);
    step("store16",    5'd17, 64'd16, 64'h00000000CAFEF00D, 0, 1, 0, 0, 4'b0000, 64'd0,   0, 64'd0,                 0);
    step("load16",     5'd18, 64'd16, 64'd0,                1, 0, 1, 1, 4'b0000, 64'd0,   0, 64'h00000000CAFEF00D,  0);

    // Reset asserted between edges while a store to addr 16 is pending.
    @(negedge clk);
    EX_MEM_Rd = 5'd19; EX_MEM_ALU = 64'd16; EX_MEM_MUX_FB = 64'h5555AAAA5555AAAA;
    EX_MEM_MemWrite = 1'b1; EX_MEM_RegWrite = 1'b1;
    #1 reset = 1'b1;
    #1;
    check("mid_reset.memwb", obs_fields(), 136'd0);
    check("mid_reset.count", {120'd0, Taken_Count}, 136'd0);
    exp_cnt = 16'd0;
    // Branch resolution must ignore reset.
    EX_MEM_BranchEq = 1'b1; EX_MEM_zero = 1'b1; EX_MEM_Adder = 64'h1234;
    #1;
    check("reset_branch.pcsrc", {135'd0, PCSrc}, 136'd1);
    check("reset_branch.target", {72'd0, Branch_Target}, {72'd0, 64'h1234});
    @(posedge clk);
    #1;
    check("reset_hold.memwb", obs_fields(), 136'd0);
    check("reset_hold.count", {120'd0, Taken_Count}, 136'd0);
    @(negedge clk);
    set_idle();
    reset = 1'b0;

    step("load16_rst", 5'd20, 64'd16, 64'd0,                1, 0, 1, 1, 4'b0000, 64'd0,   0, 64'd0,                 0);
    step("load8_rst",  5'd21, 64'd8,  64'd0,                1, 0, 1, 1, 4'b0000, 64'd0,   0, 64'd0,                 0);

    // Saturation: run the counter up to 0xFFFE, then three more taken branches.
    @(negedge clk);
    EX_MEM_BranchEq = 1'b1; EX_MEM_zero = 1'b1;
    repeat (65534) @(posedge clk);
    #1;
    exp_cnt = 16'hFFFE;
    check("preload.count", {120'd0, Taken_Count}, {120'd0, exp_cnt});
    step("sat1",       5'd22, 64'd0,  64'd0,                0, 0, 0, 0, 4'b1010, 64'h40,  1, 64'd0,                 0);
    step("sat2",       5'd23, 64'd0,  64'd0,                0, 0, 0, 0, 4'b1010, 64'h40,  1, 64'd0,                 0);
    step("sat3",       5'd24, 64'd0,  64'd0,                0, 0, 0, 0, 4'b0101, 64'h44,  1, 64'd0,                 0);
    check("sat.final", {120'd0, Taken_Count}, {120'd0, 16'hFFFF});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
